// File: rtl/ros2_pub_scheduler.sv
// ros2_pub_scheduler
// Periodic publisher scheduler. Each channel has a period counter. When a
// channel's period elapses, a message for that channel is marked pending.
// Pending channels are served round-robin through a req/grant/rel handshake
// with the ros2_ether publisher buffer.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   ch_en, ch_period        per-channel enable and period (0 = idle)
//   ch_data, ch_len         per-channel payload and byte length
//   app_data, app_data_len  payload/length of the channel being served
//   app_data_req/_grant/_rel  handshake with ros2_ether
//   ch_seq, ch_sent         per-channel sequence number, sent pulse
//   ch_overrun, overrun_clr sticky overrun flags and their clears
//   busy                    transaction in progress (REQ or REL)

`ifndef ROS2_MAX_APP_DATA_LEN
`define ROS2_MAX_APP_DATA_LEN 32
`endif

module ros2_pub_scheduler #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned CNT_W  = 28,
   parameter int unsigned DATA_W = `ROS2_MAX_APP_DATA_LEN * 8,
   parameter int unsigned SEQ_W  = 8,
   parameter logic [SEQ_W-1:0] SEQ_INIT = SEQ_W'(48),
   parameter logic [SEQ_W-1:0] SEQ_MAX  = SEQ_W'(57)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_CH-1:0]         ch_en,
   input  logic [NUM_CH*CNT_W-1:0]   ch_period,
   input  logic [NUM_CH*DATA_W-1:0]  ch_data,
   input  logic [NUM_CH*8-1:0]       ch_len,
   output logic [DATA_W-1:0]         app_data,
   output logic [7:0]                app_data_len,
   output logic                      app_data_req,
   input  logic                      app_data_grant,
   output logic                      app_data_rel,
   output logic [NUM_CH*SEQ_W-1:0]   ch_seq,
   output logic [NUM_CH-1:0]         ch_sent,
   output logic [NUM_CH-1:0]         ch_overrun,
   input  logic [NUM_CH-1:0]         overrun_clr,
   output logic                      busy
);

   localparam int unsigned SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_REL  = 2'd2;

   logic [1:0]       state, state_d;
   logic [SEL_W-1:0] sel, sel_d;
   logic [SEL_W-1:0] last_sel, last_sel_d;
   logic [SEL_W-1:0] rr_sel;
   logic             rr_found;
   logic             req_d, rel_d, grant_hit, start;

   logic [CNT_W-1:0] cnt [NUM_CH];
   logic [NUM_CH-1:0] pend, pend_d, elapse, gnt_clr, ovr_d;
   logic [DATA_W-1:0] data_mux;
   logic [7:0]        len_mux;

   // Period elapse; >= makes a shortened period fire on the next cycle
   always_comb begin
      elapse = '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         elapse[i] = ch_en[i] && (ch_period[i*CNT_W +: CNT_W] != '0) &&
                     (cnt[i] >= ch_period[i*CNT_W +: CNT_W] - CNT_W'(1));
      end
   end

   // Round-robin pick, searching from last_sel+1
   always_comb begin
      rr_sel   = '0;
      rr_found = 1'b0;
      for (int k = 1; k <= int'(NUM_CH); k++) begin
         for (int j = 0; j < int'(NUM_CH); j++) begin
            if (!rr_found && pend[j] &&
                (j == (int'(last_sel) + k) % int'(NUM_CH))) begin
               rr_found = 1'b1;
               rr_sel   = SEL_W'(j);
            end
         end
      end
   end

   // Payload mux for the channel about to be served
   always_comb begin
      data_mux = '0;
      len_mux  = '0;
      for (int j = 0; j < int'(NUM_CH); j++) begin
         if (rr_sel == SEL_W'(j)) begin
            data_mux = ch_data[j*DATA_W +: DATA_W];
            len_mux  = ch_len[j*8 +: 8];
         end
      end
   end

   // Next state and handshake controls
   always_comb begin
      state_d    = state;
      sel_d      = sel;
      last_sel_d = last_sel;
      req_d      = 1'b0;
      rel_d      = 1'b0;
      grant_hit  = 1'b0;
      start      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (rr_found) begin
               sel_d   = rr_sel;
               req_d   = 1'b1;
               start   = 1'b1;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            req_d = 1'b1;
            if (app_data_grant) begin
               req_d     = 1'b0;
               rel_d     = 1'b1;
               grant_hit = 1'b1;
               state_d   = ST_REL;
            end
         end
         ST_REL: begin
            last_sel_d = sel;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Pending/overrun updates; a new elapse always wins over any clear.
   // A disabled channel keeps its pend only while it owns the transaction.
   always_comb begin
      pend_d  = '0;
      ovr_d   = '0;
      gnt_clr = '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         gnt_clr[i] = grant_hit && (int'(sel) == i);
         pend_d[i]  = elapse[i] |
                      (pend[i] & ~gnt_clr[i] &
                       ~(!ch_en[i] && !((state != ST_IDLE) && (int'(sel) == i))));
         ovr_d[i]   = (elapse[i] & pend[i]) | (ch_overrun[i] & ~overrun_clr[i]);
      end
   end

   // State register and handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         sel          <= '0;
         last_sel     <= SEL_W'(NUM_CH - 1);
         app_data_req <= 1'b0;
         app_data_rel <= 1'b0;
         busy         <= 1'b0;
         app_data     <= '0;
         app_data_len <= '0;
      end else begin
         state        <= state_d;
         sel          <= sel_d;
         last_sel     <= last_sel_d;
         app_data_req <= req_d;
         app_data_rel <= rel_d;
         busy         <= (state_d != ST_IDLE);
         if (start) begin
            app_data     <= data_mux;
            app_data_len <= len_mux;
         end
      end
   end

   // Per-channel counters, pending, flags and sequence numbers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(NUM_CH); i++) begin
            cnt[i]                   <= '0;
            ch_seq[i*SEQ_W +: SEQ_W] <= SEQ_INIT;
         end
         pend       <= '0;
         ch_sent    <= '0;
         ch_overrun <= '0;
      end else begin
         for (int i = 0; i < int'(NUM_CH); i++) begin
            if (!ch_en[i] || (ch_period[i*CNT_W +: CNT_W] == '0) || elapse[i])
               cnt[i] <= '0;
            else
               cnt[i] <= cnt[i] + CNT_W'(1);
            if (gnt_clr[i]) begin
               ch_seq[i*SEQ_W +: SEQ_W] <= (ch_seq[i*SEQ_W +: SEQ_W] == SEQ_MAX) ?
                                           SEQ_INIT : ch_seq[i*SEQ_W +: SEQ_W] + SEQ_W'(1);
            end
         end
         pend       <= pend_d;
         ch_sent    <= gnt_clr;
         ch_overrun <= ovr_d;
      end
   end

endmodule

// File: tb/tb_ros2_pub_scheduler.sv
// Directed testbench for ros2_pub_scheduler (NUM_CH=2, CNT_W=8, DATA_W=32).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.

module tb_ros2_pub_scheduler;

   localparam int unsigned NUM_CH = 2;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned SEQ_W  = 8;

   localparam logic [31:0] D0 = 32'hA0A0_0001;
   localparam logic [31:0] D1 = 32'hB1B1_0002;
   localparam logic [7:0]  L0 = 8'd4;
   localparam logic [7:0]  L1 = 8'd3;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic [NUM_CH-1:0]        ch_en;
   logic [NUM_CH*CNT_W-1:0]  ch_period;
   logic [NUM_CH*DATA_W-1:0] ch_data;
   logic [NUM_CH*8-1:0]      ch_len;
   logic [DATA_W-1:0]        app_data;
   logic [7:0]               app_data_len;
   logic                     app_data_req;
   logic                     app_data_grant;
   logic                     app_data_rel;
   logic [NUM_CH*SEQ_W-1:0]  ch_seq;
   logic [NUM_CH-1:0]        ch_sent;
   logic [NUM_CH-1:0]        ch_overrun;
   logic [NUM_CH-1:0]        overrun_clr;
   logic                     busy;

   int n_pass  = 0;
   int n_total = 0;

   ros2_pub_scheduler #(
      .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DATA_W(DATA_W), .SEQ_W(SEQ_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .ch_period(ch_period),
      .ch_data(ch_data), .ch_len(ch_len), .app_data(app_data),
      .app_data_len(app_data_len), .app_data_req(app_data_req),
      .app_data_grant(app_data_grant), .app_data_rel(app_data_rel),
      .ch_seq(ch_seq), .ch_sent(ch_sent), .ch_overrun(ch_overrun),
      .overrun_clr(overrun_clr), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      ch_en          = '0;
      ch_period      = '0;
      app_data_grant = 1'b0;
      overrun_clr    = '0;
      tick(2);
      rst_n = 1'b1;
   endtask

   task automatic wait_req(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (app_data_req === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick(1);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(1);
      n_total++; if (app_data_req !== 1'b0) $display("FAIL rst_req got=%b exp=0", app_data_req); else n_pass++;
      n_total++; if (app_data_rel !== 1'b0) $display("FAIL rst_rel got=%b exp=0", app_data_rel); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else n_pass++;
      n_total++; if (ch_seq !== 16'h3030) $display("FAIL rst_seq got=%h exp=3030", ch_seq); else n_pass++;
      n_total++; if ({ch_sent, ch_overrun} !== 4'b0) $display("FAIL rst_flags got=%b exp=0000", {ch_sent, ch_overrun}); else n_pass++;
      n_total++; if ({app_data, app_data_len} !== 40'h0) $display("FAIL rst_data got=%h exp=0", {app_data, app_data_len}); else n_pass++;
      do_reset();
   endtask

   task automatic test_basic();
      do_reset();
      ch_period = {8'd0, 8'd4};
      ch_en     = 2'b01;
      tick(4);
      n_total++; if (app_data_req !== 1'b0) $display("FAIL basic_no_req_e4 got=%b exp=0", app_data_req); else n_pass++;
      tick(1);
      n_total++; if (app_data_req !== 1'b1) $display("FAIL basic_req_e5 got=%b exp=1", app_data_req); else n_pass++;
      n_total++; if (app_data !== D0 || app_data_len !== L0) $display("FAIL basic_data got=%h/%0d exp=%h/%0d", app_data, app_data_len, D0, L0); else n_pass++;
      n_total++; if (busy !== 1'b1) $display("FAIL basic_busy got=%b exp=1", busy); else n_pass++;
      app_data_grant = 1'b1;
      tick(1);
      app_data_grant = 1'b0;
      n_total++; if ({app_data_req, app_data_rel} !== 2'b01) $display("FAIL basic_grant_reqrel got=%b exp=01", {app_data_req, app_data_rel}); else n_pass++;
      n_total++; if (ch_sent !== 2'b01) $display("FAIL basic_sent got=%b exp=01", ch_sent); else n_pass++;
      n_total++; if (ch_seq[7:0] !== 8'd49) $display("FAIL basic_seq got=%0d exp=49", ch_seq[7:0]); else n_pass++;
      n_total++; if (app_data !== D0) $display("FAIL basic_data_rel got=%h exp=%h", app_data, D0); else n_pass++;
      tick(1);
      n_total++; if ({app_data_rel, ch_sent} !== 3'b000) $display("FAIL basic_rel_one_cycle got=%b exp=000", {app_data_rel, ch_sent}); else n_pass++;
   endtask

   task automatic test_seq_wrap();
      bit ok;
      logic [7:0] exp_seq;
      do_reset();
      ch_period = {8'd0, 8'd2};
      ch_en     = 2'b01;
      exp_seq   = 8'd48;
      for (int g = 0; g < 11; g++) begin
         wait_req(ok);
         n_total++;
         if (!ok) begin
            $display("FAIL wrap_req_timeout got=timeout exp=req grant=%0d", g);
            break;
         end else n_pass++;
         app_data_grant = 1'b1;
         tick(1);
         app_data_grant = 1'b0;
         exp_seq = (exp_seq == 8'd57) ? 8'd48 : exp_seq + 8'd1;
         n_total++; if (ch_seq[7:0] !== exp_seq) $display("FAIL wrap_seq grant=%0d got=%0d exp=%0d", g, ch_seq[7:0], exp_seq); else n_pass++;
      end
      n_total++; if (ch_seq[15:8] !== 8'd48) $display("FAIL wrap_seq_ch1 got=%0d exp=48", ch_seq[15:8]); else n_pass++;
   endtask

   task automatic test_round_robin();
      bit ok;
      int exp_ch;
      do_reset();
      ch_period = {8'd4, 8'd4};
      ch_en     = 2'b11;
      for (int s = 0; s < 4; s++) begin
         exp_ch = s % 2;
         wait_req(ok);
         n_total++;
         if (!ok) begin
            $display("FAIL rr_req_timeout got=timeout exp=req serve=%0d", s);
            break;
         end else n_pass++;
         n_total++; if (app_data !== ((exp_ch == 1) ? D1 : D0)) $display("FAIL rr_data serve=%0d got=%h exp_ch=%0d", s, app_data, exp_ch); else n_pass++;
         app_data_grant = 1'b1;
         tick(1);
         app_data_grant = 1'b0;
         n_total++; if (ch_sent !== 2'(1 << exp_ch)) $display("FAIL rr_sent serve=%0d got=%b exp_ch=%0d", s, ch_sent, exp_ch); else n_pass++;
      end
   endtask

   task automatic test_overrun();
      bit ok;
      int sent_cnt;
      do_reset();
      ch_period = {8'd0, 8'd4};
      ch_en     = 2'b01;
      sent_cnt  = 0;
      wait_req(ok);
      n_total++; if (!ok) $display("FAIL ovr_req_timeout got=timeout exp=req"); else n_pass++;
      for (int c = 0; c < 11; c++) begin
         tick(1);
         if (ch_sent[0]) sent_cnt++;
      end
      n_total++; if (ch_overrun !== 2'b01) $display("FAIL ovr_set got=%b exp=01", ch_overrun); else n_pass++;
      n_total++; if (app_data_req !== 1'b1) $display("FAIL ovr_req_held got=%b exp=1", app_data_req); else n_pass++;
      app_data_grant = 1'b1;
      tick(1);
      app_data_grant = 1'b0;
      if (ch_sent[0]) sent_cnt++;
      ch_en = 2'b00;
      tick(1);
      if (ch_sent[0]) sent_cnt++;
      n_total++; if (sent_cnt !== 1) $display("FAIL ovr_single_msg got=%0d exp=1", sent_cnt); else n_pass++;
      n_total++; if (ch_overrun !== 2'b01) $display("FAIL ovr_sticky got=%b exp=01", ch_overrun); else n_pass++;
      overrun_clr = 2'b01;
      tick(1);
      overrun_clr = 2'b00;
      n_total++; if (ch_overrun !== 2'b00) $display("FAIL ovr_clr got=%b exp=00", ch_overrun); else n_pass++;
      n_total++; if (app_data_req !== 1'b0) $display("FAIL ovr_no_extra_req got=%b exp=0", app_data_req); else n_pass++;
   endtask

   task automatic test_coincident();
      do_reset();
      ch_period = {8'd4, 8'd0};
      ch_en     = 2'b10;
      tick(5);
      n_total++; if (app_data_req !== 1'b1) $display("FAIL coin_req_e5 got=%b exp=1", app_data_req); else n_pass++;
      n_total++; if (app_data !== D1 || app_data_len !== L1) $display("FAIL coin_data got=%h/%0d exp=%h/%0d", app_data, app_data_len, D1, L1); else n_pass++;
      tick(2);
      app_data_grant = 1'b1;
      tick(1);
      app_data_grant = 1'b0;
      n_total++; if ({app_data_rel, ch_sent} !== 3'b110) $display("FAIL coin_grant got=%b exp=110", {app_data_rel, ch_sent}); else n_pass++;
      n_total++; if (ch_overrun !== 2'b10) $display("FAIL coin_overrun got=%b exp=10", ch_overrun); else n_pass++;
      tick(1);
      n_total++; if ({app_data_req, app_data_rel} !== 2'b00) $display("FAIL coin_gap got=%b exp=00", {app_data_req, app_data_rel}); else n_pass++;
      tick(1);
      n_total++; if (app_data_req !== 1'b1) $display("FAIL coin_second_req got=%b exp=1", app_data_req); else n_pass++;
      n_total++; if (ch_seq[15:8] !== 8'd49) $display("FAIL coin_seq got=%0d exp=49", ch_seq[15:8]); else n_pass++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      ch_period = {8'd0, 8'd4};
      ch_en     = 2'b01;
      tick(5);
      n_total++; if (app_data_req !== 1'b1) $display("FAIL rmid_req got=%b exp=1", app_data_req); else n_pass++;
      app_data_grant = 1'b1;
      rst_n          = 1'b0;
      #1;
      n_total++; if ({app_data_req, app_data_rel, busy} !== 3'b000) $display("FAIL rmid_async got=%b exp=000", {app_data_req, app_data_rel, busy}); else n_pass++;
      n_total++; if (ch_seq !== 16'h3030) $display("FAIL rmid_seq got=%h exp=3030", ch_seq); else n_pass++;
      tick(2);
      n_total++; if (app_data_rel !== 1'b0) $display("FAIL rmid_no_rel got=%b exp=0", app_data_rel); else n_pass++;
      app_data_grant = 1'b0;
      ch_en          = 2'b00;
      rst_n          = 1'b1;
      tick(2);
      n_total++; if ({app_data_req, app_data_rel, busy} !== 3'b000) $display("FAIL rmid_idle got=%b exp=000", {app_data_req, app_data_rel, busy}); else n_pass++;
   endtask

   task automatic test_grant_ignored();
      do_reset();
      app_data_grant = 1'b1;
      tick(3);
      app_data_grant = 1'b0;
      n_total++; if ({app_data_rel, ch_sent} !== 3'b000) $display("FAIL gign_rel got=%b exp=000", {app_data_rel, ch_sent}); else n_pass++;
      n_total++; if (ch_seq !== 16'h3030) $display("FAIL gign_seq got=%h exp=3030", ch_seq); else n_pass++;
   endtask

   initial begin
      rst_n          = 1'b0;
      ch_en          = '0;
      ch_period      = '0;
      ch_data        = {D1, D0};
      ch_len         = {L1, L0};
      app_data_grant = 1'b0;
      overrun_clr    = '0;
      test_reset();
      test_basic();
      test_seq_wrap();
      test_round_robin();
      test_overrun();
      test_coincident();
      test_reset_mid();
      test_grant_ignored();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
